alu_opa_seq: RTL and testbench

//  Sequential, parametrised successor to the single-operand A-path ALU unit.

---
 rtl/alu_opa_seq.sv | 206 ++++++++++++++++++++
 tb/tb_alu_opa_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_opa_seq.sv
// Sequential single-operand ALU: INC/DEC/NOT in one cycle, bit-serial shifts and rotates.
// One request in flight; the registered result is held until the consumer accepts it.
module alu_opa_seq #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4,
    localparam int SHAMT_W  = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mode,
    input  logic [CMD_WIDTH-1:0] cmd,
    input  logic [WIDTH-1:0]     opa,
    input  logic [SHAMT_W-1:0]   shamt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH:0]       res,
    output logic                 cout,
    output logic                 oflow,
    output logic                 err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        K_SHR,
        K_SHL,
        K_ROR,
        K_ROL
    } kind_t;

    localparam logic [CMD_WIDTH-1:0] CMD_INC = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] CMD_DEC = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] CMD_NOT = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] CMD_SHR = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] CMD_SHL = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] CMD_ROR = CMD_WIDTH'(3);
    localparam logic [CMD_WIDTH-1:0] CMD_ROL = CMD_WIDTH'(4);

    localparam logic [WIDTH:0]       RES_ONE = (WIDTH + 1)'(1);
    localparam logic [SHAMT_W-1:0]   CNT_ONE = SHAMT_W'(1);

    state_t               state_q, state_d;
    kind_t                kind_q, kind_d;
    logic [WIDTH-1:0]     work_q, work_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]       res_q, res_d;
    logic                 cout_q, cout_d;
    logic                 oflow_q, oflow_d;
    logic                 err_q, err_d;

    logic [WIDTH:0]       opa_ext;
    logic [WIDTH:0]       inc_val;
    logic [WIDTH:0]       dec_val;
    logic [WIDTH-1:0]     step_val;
    logic                 step_out;
    logic                 shift_cmd;
    kind_t                shift_kind;

    assign opa_ext = {1'b0, opa};
    // The (WIDTH+1)-bit subtract wraps 0 to all ones, which is the required DEC result.
    assign inc_val = opa_ext + RES_ONE;
    assign dec_val = opa_ext - RES_ONE;

    // Map logical commands onto the shift/rotate kind; anything else is not a shift.
    always_comb begin
        shift_cmd  = 1'b1;
        shift_kind = K_SHR;
        case (cmd)
            CMD_SHR: shift_kind = K_SHR;
            CMD_SHL: shift_kind = K_SHL;
            CMD_ROR: shift_kind = K_ROR;
            CMD_ROL: shift_kind = K_ROL;
            default: shift_cmd  = 1'b0;
        endcase
    end

    // One-bit step of the working register; step_out is the bit leaving it.
    always_comb begin
        step_val = work_q;
        step_out = 1'b0;
        case (kind_q)
            K_SHR: begin
                step_val = {1'b0, work_q[WIDTH-1:1]};
                step_out = work_q[0];
            end
            K_SHL: begin
                step_val = {work_q[WIDTH-2:0], 1'b0};
                step_out = work_q[WIDTH-1];
            end
            K_ROR: step_val = {work_q[0], work_q[WIDTH-1:1]};
            K_ROL: step_val = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
            default: step_val = work_q;
        endcase
    end

    // State register and datapath registers; reset is synchronous and overrides everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            kind_q  <= K_SHR;
            work_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            oflow_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            oflow_q <= oflow_d;
            err_q   <= err_d;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        // NOTE: every variable gets a hold-value default first, so no path can infer a latch.
        state_d = state_q;
        kind_d  = kind_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        cout_d  = cout_q;
        oflow_d = oflow_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_DONE;
                    res_d   = '0;
                    cout_d  = 1'b0;
                    oflow_d = 1'b0;
                    err_d   = 1'b0;
                    if (mode) begin
                        if (cmd == CMD_INC) begin
                            res_d  = inc_val;
                            cout_d = inc_val[WIDTH];
                        end else if (cmd == CMD_DEC) begin
                            res_d   = dec_val;
                            oflow_d = (opa == '0);
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (cmd == CMD_NOT) begin
                        res_d = {1'b0, ~opa};
                    end else if (shift_cmd) begin
                        // A zero amount skips the shift state and returns the operand unchanged.
                        if (shamt == '0) begin
                            res_d = opa_ext;
                        end else begin
                            state_d = S_SHIFT;
                            kind_d  = shift_kind;
                            work_d  = opa;
                            cnt_d   = shamt;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_SHIFT: begin
                work_d = step_val;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DONE;
                    res_d   = {1'b0, step_val};
                    cout_d  = (kind_q == K_SHR || kind_q == K_SHL) ? step_out : 1'b0;
                    oflow_d = 1'b0;
                    err_d   = 1'b0;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: handshake flags from state, result fields straight from registers.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        res       = res_q;
        cout      = cout_q;
        oflow     = oflow_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_alu_opa_seq.sv
// Self-checking bench for alu_opa_seq: directed scenarios plus randomized requests
// compared against an arithmetic reference model.
module tb_alu_opa_seq;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       mode;
    logic [3:0] cmd;
    logic [7:0] opa;
    logic [2:0] shamt;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] res;
    logic       cout;
    logic       oflow;
    logic       err;

    int n_cmp = 0;
    int n_mis = 0;

    alu_opa_seq #(.WIDTH(8), .CMD_WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .cmd       (cmd),
        .opa       (opa),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .cout      (cout),
        .oflow     (oflow),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: results derived with plain integer arithmetic from the command rules.
    function automatic void model(input int m, input int c, input int a, input int s,
                                  output int r, output int co, output int of,
                                  output int er, output int lat);
        r = 0; co = 0; of = 0; er = 0; lat = 1;
        if (m != 0) begin
            if (c == 0) begin
                r  = a + 1;
                co = r >> W;
            end else if (c == 1) begin
                r  = (a == 0) ? (1 << (W + 1)) - 1 : a - 1;
                of = (a == 0) ? 1 : 0;
            end else begin
                er = 1;
            end
        end else begin
            case (c)
                0: r = ~a & MASK;
                1: begin
                    r  = a >> s;
                    co = (s == 0) ? 0 : (a >> (s - 1)) & 1;
                    lat = s + 1;
                end
                2: begin
                    r  = (a << s) & MASK;
                    co = (s == 0) ? 0 : (a >> (W - s)) & 1;
                    lat = s + 1;
                end
                3: begin
                    r  = ((a >> s) | (a << (W - s))) & MASK;
                    lat = s + 1;
                end
                4: begin
                    r  = ((a << s) | (a >> (W - s))) & MASK;
                    lat = s + 1;
                end
                default: er = 1;
            endcase
        end
    endfunction

    // Issue one request, measure latency, check result, hold it for 'hold' cycles, then accept.
    task automatic run_req(input string tag, input int m, input int c, input int a,
                           input int s, input int hold);
        int r, co, of, er, lat, k;
        model(m, c, a, s, r, co, of, er, lat);
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        mode      = m[0];
        cmd       = 4'(c);
        opa       = 8'(a);
        shamt     = 3'(s);
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        k = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            k++;
        end while (!out_valid && k < 40);
        check({tag, "_latency"}, 32'(k), 32'(lat));
        check({tag, "_res"}, 32'(res), 32'(r));
        check({tag, "_cout"}, 32'(cout), 32'(co));
        check({tag, "_oflow"}, 32'(oflow), 32'(of));
        check({tag, "_err"}, 32'(err), 32'(er));
        check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_res"}, 32'(res), 32'(r));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_res_retained"}, 32'(res), 32'(r));
        out_ready = 1'b0;
    endtask

    initial begin
        int m, c, a, s, hold, seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        mode      = 1'b0;
        cmd       = '0;
        opa       = '0;
        shamt     = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_res", 32'(res), 32'd0);
        check("reset_flags", 32'({cout, oflow, err}), 32'd0);
        rst = 1'b0;

        // Reset in the middle of a ROL by 5: no stale result may surface.
        @(negedge clk);
        mode = 1'b0; cmd = 4'd4; opa = 8'hA5; shamt = 3'd5; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("midshift_busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midshift_rst_valid", 32'(out_valid), 32'd0);
        check("midshift_rst_res", 32'(res), 32'd0);
        check("midshift_rst_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midshift_no_stale", 32'(seen), 32'd0);

        run_req("inc_ff", 1, 0, 8'hFF, 0, 0);
        run_req("dec_00", 1, 1, 8'h00, 0, 0);
        run_req("shl_81_3", 0, 2, 8'h81, 3, 0);
        run_req("shr_05_1", 0, 1, 8'h05, 1, 0);
        run_req("ror_01_7", 0, 3, 8'h01, 7, 0);
        run_req("rol_a5_0", 0, 4, 8'hA5, 0, 0);
        run_req("illegal_f", 0, 15, 8'h3C, 2, 0);
        run_req("inc_after_err", 1, 0, 8'h10, 0, 0);
        run_req("illegal_m1", 1, 7, 8'h42, 0, 1);

        // Backpressure: NOT held for 5 cycles while a new request waits on in_valid.
        @(negedge clk);
        mode = 1'b0; cmd = 4'd0; opa = 8'h0F; shamt = 3'd0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        mode = 1'b1; cmd = 4'd0; opa = 8'h33;
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_res", 32'(res), 32'h0F0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (res !== 9'h0F0 || in_ready !== 1'b0 || out_valid !== 1'b1) seen++;
        end
        check("bp_held", 32'(seen), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_res", 32'(res), 32'h034);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_next_drop", 32'(out_valid), 32'd0);

        // Randomized requests, mostly legal, with random consumer stalls.
        for (int i = 0; i < 40; i++) begin
            m    = int'($urandom_range(0, 1));
            c    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 15))
                                               : int'($urandom_range(0, (m != 0) ? 1 : 4));
            a    = int'($urandom_range(0, 255));
            s    = int'($urandom_range(0, 7));
            hold = int'($urandom_range(0, 3));
            run_req($sformatf("rnd%0d", i), m, c, a, s, hold);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
